// File: rtl/immediate_packer.sv
// Packs a two's-complement immediate into the I/S/B/J/U fields of an instruction word.
// The result sits in a one-entry registered output stage, and a saturating counter tracks accepted errors.
module immediate_packer #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           imm_select,
  input  logic [31:0]          imm_value,
  input  logic [31:0]          base_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [1:0]           out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    SEL_I = 3'b000,
    SEL_S = 3'b001,
    SEL_J = 3'b010,
    SEL_B = 3'b011,
    SEL_U = 3'b100
  } immSel_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'b00,
    ERR_RANGE    = 2'b01,
    ERR_MISALIGN = 2'b10,
    ERR_SELECT   = 2'b11
  } errCode_e;

  logic                 accept;
  logic [31:0]          packedInstr;
  logic [1:0]           packedErr;
  logic                 fits12;
  logic                 fits13;
  logic                 fits21;
  logic                 outValidQ;
  logic [31:0]          outInstrQ;
  logic [1:0]           outErrQ;
  logic [ERR_CNT_W-1:0] errCountQ;

  assign in_ready = !outValidQ || out_ready;
  assign accept   = in_valid && in_ready;

  // A value fits in N signed bits when every bit from N-1 upward is a copy of the sign.
  assign fits12 = (&imm_value[31:11]) || !(|imm_value[31:11]);
  assign fits13 = (&imm_value[31:12]) || !(|imm_value[31:12]);
  assign fits21 = (&imm_value[31:20]) || !(|imm_value[31:20]);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    packedInstr = base_instr;
    packedErr   = ERR_OK;
    case (imm_select)
      SEL_I: begin
        packedInstr[31:20] = imm_value[11:0];
        if (!fits12) packedErr = ERR_RANGE;
      end
      SEL_S: begin
        packedInstr[31:25] = imm_value[11:5];
        packedInstr[11:7]  = imm_value[4:0];
        if (!fits12) packedErr = ERR_RANGE;
      end
      SEL_B: begin
        packedInstr[31]    = imm_value[12];
        packedInstr[30:25] = imm_value[10:5];
        packedInstr[11:8]  = imm_value[4:1];
        packedInstr[7]     = imm_value[11];
        if (imm_value[0])  packedErr = ERR_MISALIGN;
        else if (!fits13)  packedErr = ERR_RANGE;
      end
      SEL_J: begin
        packedInstr[31]    = imm_value[20];
        packedInstr[30:21] = imm_value[10:1];
        packedInstr[20]    = imm_value[11];
        packedInstr[19:12] = imm_value[19:12];
        if (imm_value[0])  packedErr = ERR_MISALIGN;
        else if (!fits21)  packedErr = ERR_RANGE;
      end
      SEL_U: begin
        packedInstr[31:12] = imm_value[31:12];
        if (|imm_value[11:0]) packedErr = ERR_MISALIGN;
      end
      default: packedErr = ERR_SELECT;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValidQ <= 1'b0;
      outInstrQ <= '0;
      outErrQ   <= ERR_OK;
    end else if (accept) begin
      outValidQ <= 1'b1;
      outInstrQ <= packedInstr;
      outErrQ   <= packedErr;
    end else if (out_ready) begin
      outValidQ <= 1'b0;
    end
  end

  // The clear takes priority over a same-cycle counted error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCountQ <= '0;
    end else if (err_clr) begin
      errCountQ <= '0;
    end else if (accept && (packedErr != ERR_OK) && (errCountQ != {ERR_CNT_W{1'b1}})) begin
      errCountQ <= errCountQ + ERR_CNT_W'(1);
    end
  end

  assign out_valid = outValidQ;
  assign out_instr = outInstrQ;
  assign out_err   = outErrQ;
  assign err_count = errCountQ;

endmodule

// File: tb/tb_immediate_packer.sv
// Self-checking bench for immediate_packer: directed vectors, backpressure, counter saturation,
// a random scoreboard run with round-trip decoding, and asynchronous reset mid-stream.
module tb_immediate_packer;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    imm_select;
  logic [31:0]   imm_value;
  logic [31:0]   base_instr;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [1:0]    out_err;
  logic          err_clr;
  logic [CW-1:0] err_count;

  immediate_packer #(.ERR_CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_select (imm_select),
    .imm_value  (imm_value),
    .base_instr (base_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .err_clr    (err_clr),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;
  int errModel = 0;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] base;
    logic [31:0] expInstr;
    logic [1:0]  expErr;
  } vec_t;

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] imm;
    logic [31:0] expInstr;
    logic [1:0]  expErr;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: signed-range arithmetic plus shift/mask placement of each field.
  function automatic void refPack(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base,
                                  output logic [31:0] instr, output logic [1:0] err);
    longint v;
    logic [31:0] mask, fld;
    bit outOfRange, misaligned;
    v = longint'($signed(imm));
    mask = 32'h0; fld = 32'h0; outOfRange = 0; misaligned = 0;
    case (sel)
      3'd0: begin
        mask = 32'hFFF0_0000; fld = (imm & 32'hFFF) << 20;
        outOfRange = (v < -2048) || (v > 2047);
      end
      3'd1: begin
        mask = 32'hFE00_0F80; fld = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
        outOfRange = (v < -2048) || (v > 2047);
      end
      3'd2: begin
        mask = 32'hFFFF_F000;
        fld = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
              (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
        outOfRange = (v < -1048576) || (v > 1048575);
        misaligned = (imm % 2) != 0;
      end
      3'd3: begin
        mask = 32'hFE00_0F80;
        fld = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
              (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
        outOfRange = (v < -4096) || (v > 4095);
        misaligned = (imm % 2) != 0;
      end
      3'd4: begin
        mask = 32'hFFFF_F000; fld = imm & 32'hFFFF_F000;
        misaligned = (imm % 4096) != 0;
      end
      default: ;
    endcase
    instr = (base & ~mask) | fld;
    if (sel > 3'd4)      err = 2'b11;
    else if (misaligned) err = 2'b10;
    else if (outOfRange) err = 2'b01;
    else                 err = 2'b00;
  endfunction

  // Core immediate decode, used for the round-trip check.
  function automatic logic [31:0] decode(input logic [2:0] sel, input logic [31:0] i);
    case (sel)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {i[31:12], 12'h0};
    endcase
  endfunction

  function automatic void noteAccept(input logic [1:0] err, input logic clr);
    if (clr) errModel = 0;
    else if (err != 2'b00 && errModel < (1 << CW) - 1) errModel++;
  endfunction

  task automatic drive(input logic v, input logic [2:0] s, input logic [31:0] i, input logic [31:0] b);
    in_valid = v; imm_select = s; imm_value = i; base_instr = b;
  endtask

  vec_t vecs[$];
  exp_t sb[$];
  exp_t e;
  logic [31:0] ri, rb, xi;
  logic [2:0]  rs;
  logic [1:0]  xe;
  logic [31:0] heldInstr;
  logic [1:0]  heldErr;
  logic [31:0] strmInstr[4];
  logic [1:0]  strmErr[4];

  initial begin
    vecs.push_back('{3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 2'b00});
    vecs.push_back('{3'd3, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 2'b00});
    vecs.push_back('{3'd3, 32'h0000_0FFF, 32'h0000_0063, 32'h7E00_0FE3, 2'b10});
    vecs.push_back('{3'd2, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 2'b01});
    vecs.push_back('{3'd7, 32'h0000_0ABC, 32'h1234_5678, 32'h1234_5678, 2'b11});
    vecs.push_back('{3'd1, 32'h0000_07FF, 32'h0000_0023, 32'h7E00_0FA3, 2'b00});
    vecs.push_back('{3'd4, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 2'b00});
    vecs.push_back('{3'd4, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 2'b10});
    vecs.push_back('{3'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 2'b01});
    vecs.push_back('{3'd3, 32'h0000_1001, 32'h0000_0063, 32'h8000_0063, 2'b10});
    vecs.push_back('{3'd5, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11});
    vecs.push_back('{3'd2, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 2'b00});

    rst_n = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_instr", 64'(out_instr), 64'd0);
    check("reset_out_err",   64'(out_err),   64'd0);
    check("reset_err_count", 64'(err_count), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);

    // First vector is presented as reset releases: it must be taken on the very first edge.
    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].sel, vecs[k].imm, vecs[k].base);
      if (k == 0) rst_n = 1'b1;
      noteAccept(vecs[k].expErr, 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_instr", k), 64'(out_instr), 64'(vecs[k].expInstr));
      check($sformatf("vec%0d_err",   k), 64'(out_err),   64'(vecs[k].expErr));
      check($sformatf("vec%0d_cnt",   k), 64'(err_count), 64'(errModel));
    end

    // Clear on an idle cycle, then drive the counter into saturation.
    drive(1'b0, 3'd0, 32'h0, 32'h0); err_clr = 1'b1; errModel = 0;
    @(negedge clk); err_clr = 1'b0;
    check("clr_idle_cnt", 64'(err_count), 64'd0);
    check("drain_valid",  64'(out_valid), 64'd0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'd6, 32'(k), 32'h0);
      noteAccept(2'b11, 1'b0);
      @(negedge clk);
      check($sformatf("sat%0d_cnt", k), 64'(err_count), 64'(k < 3 ? k + 1 : 3));
    end
    drive(1'b1, 3'd7, 32'h0, 32'h0); err_clr = 1'b1; noteAccept(2'b11, 1'b1);
    @(negedge clk); err_clr = 1'b0;
    check("clr_wins_cnt", 64'(err_count), 64'd0);

    // Backpressure: a held result stays put and input is refused.
    refPack(3'd1, 32'hFFFF_FFF0, 32'h0000_0023, heldInstr, heldErr);
    drive(1'b1, 3'd1, 32'hFFFF_FFF0, 32'h0000_0023);
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 32'h1, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'd0);
      @(negedge clk);
      check($sformatf("bp%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp%0d_instr", k), 64'(out_instr), 64'(heldInstr));
      check($sformatf("bp%0d_err",   k), 64'(out_err),   64'(heldErr));
    end
    check("bp_cnt_unchanged", 64'(err_count), 64'(errModel));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ri = 32'($urandom_range(0, 4095)) - 32'd2048;
      refPack(3'd0, ri, 32'h0000_0093 + 32'(k), strmInstr[k], strmErr[k]);
      drive(1'b1, 3'd0, ri, 32'h0000_0093 + 32'(k));
      @(negedge clk);
      check($sformatf("strm%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("strm%0d_instr", k), 64'(out_instr), 64'(strmInstr[k]));
      check($sformatf("strm%0d_err",   k), 64'(out_err),   64'(strmErr[k]));
    end
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    @(negedge clk);
    check("drain_to_idle", 64'(out_valid), 64'd0);

    // Random traffic with random backpressure against a one-entry scoreboard.
    for (int n = 0; n < 400; n++) begin
      rs = 3'($urandom_range(0, 4));
      case (rs)
        3'd0, 3'd1: ri = 32'($urandom_range(0, 4095)) - 32'd2048;
        3'd3:       ri = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
        3'd2:       ri = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        default:    ri = $urandom & 32'hFFFF_F000;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        rs = 3'($urandom_range(0, 7));
        ri = $urandom;
      end
      rb = $urandom;
      out_ready = 1'($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 4) != 0), rs, ri, rb);
      err_clr = 1'($urandom_range(0, 30) == 0);
      #1;
      check("rnd_in_ready", 64'(in_ready), 64'(sb.size() == 0 || out_ready));
      check("rnd_valid", 64'(out_valid), 64'(sb.size() != 0));
      if (out_valid && out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check("rnd_instr", 64'(out_instr), 64'(e.expInstr));
        check("rnd_err",   64'(out_err),   64'(e.expErr));
        if (e.expErr == 2'b00)
          check("rnd_roundtrip", 64'(decode(e.sel, out_instr)), 64'(e.imm));
      end
      if (in_valid && in_ready) begin
        refPack(rs, ri, rb, xi, xe);
        sb.push_back('{rs, ri, xi, xe});
        noteAccept(xe, err_clr);
      end else if (err_clr) begin
        errModel = 0;
      end
      @(negedge clk);
      check("rnd_cnt", 64'(err_count), 64'(errModel));
    end
    err_clr = 1'b0;

    // Asynchronous reset with a result in flight.
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 32'h0, 32'hCAFE_F00D);
    if (in_ready) noteAccept(2'b11, 1'b0);
    @(negedge clk);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_instr", 64'(out_instr), 64'd0);
    check("async_rst_err",   64'(out_err),   64'd0);
    check("async_rst_cnt",   64'(err_count), 64'd0);
    check("async_rst_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    check("rst_hold_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 3'd4, 32'hABCDE000, 32'h0000_0017);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_instr", 64'(out_instr), 64'hABCD_E017);
    check("post_rst_err",   64'(out_err),   64'd0);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/immediate_packer.md
IMMEDIATE_PACKER -- requirements
Module: immediate_packer

Interface
REQ-001 The module SHALL have parameter ERR_CNT_W, default 8, giving the width of the error counter.
REQ-002 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous reset, active low.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  request accepted this cycle when in_valid and in_ready are both high.
REQ-007 imm_select  input  3  immediate type: 000 I, 001 S, 010 J, 011 B, 100 U; 101-111 illegal.
REQ-008 imm_value  input  32  immediate value to encode, two's complement.
REQ-009 base_instr  input  32  instruction word whose immediate bit positions are replaced.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result when out_valid and out_ready are both high.
REQ-012 out_instr  output  32  instruction with the immediate packed in.
REQ-013 out_err  output  2  error code: 00 ok, 01 out of range, 10 misaligned, 11 illegal select.
REQ-014 err_clr  input  1  synchronous clear of err_count.
REQ-015 err_count  output  ERR_CNT_W  saturating count of accepted requests with out_err != 00.

Function
REQ-016 Packing SHALL be the exact inverse of the core immediate decode:
- I: [31:20] = imm[11:0].
- S: [31:25] = imm[11:5]; [11:7] = imm[4:0].
- B: [31] = imm[12]; [7] = imm[11]; [30:25] = imm[10:5]; [11:8] = imm[4:1].
- J: [31] = imm[20]; [19:12] = imm[19:12]; [20] = imm[11]; [30:21] = imm[10:1].
- U: [31:12] = imm[31:12].
REQ-017 All out_instr bits not listed for the selected type SHALL equal the corresponding base_instr bits.
REQ-018 Range checks:
- I and S: -2048..2047.
- B: -4096..4095.
- J: -1048576..1048575.
- U: no range check.
A value outside its range SHALL give out_err = 01.
REQ-019 Misalignment SHALL give out_err = 10:
- B and J: imm[0] = 1.
- U: imm[11:0] != 0.
REQ-020 imm_select of 101-111 SHALL give out_err = 11, and out_instr SHALL equal base_instr.
REQ-021 Error priority SHALL be 11 over 10 over 01.
REQ-022 When out_err is not 00, out_instr SHALL still carry the truncated packed fields, so it is deterministic.
REQ-023 The result register SHALL hold one entry; out_instr, out_err and out_valid SHALL be registered outputs.
REQ-024 in_ready SHALL equal (!out_valid || out_ready), combinationally; the datapath SHALL have no combinational input-to-output path other than this ready path.
REQ-025 An accepted request SHALL appear on the outputs with out_valid = 1 on the next cycle (latency 1).
REQ-026 Accept and drain in the same cycle SHALL load the new result with no bubble, giving throughput of 1 per cycle.
REQ-027 While out_valid = 1 and out_ready = 0, out_instr and out_err SHALL hold stable and in_ready SHALL be 0.
REQ-028 If there is no accept and the result drains, out_valid SHALL go to 0 on the next edge.
REQ-029 err_count SHALL increment by 1 at acceptance of a request whose computed error is not 00.
REQ-030 err_count SHALL saturate at 2^ERR_CNT_W - 1.
REQ-031 err_clr SHALL set err_count to 0 on the next edge; if a counted error is accepted in the same cycle, the clear SHALL win and the result SHALL be 0.
REQ-032 Inputs SHALL be ignored when in_valid = 0 or in_ready = 0.

Reset
REQ-033 While rst_n = 0, out_valid, out_instr, out_err and err_count SHALL be 0, asynchronously.
REQ-034 An in-flight result SHALL be discarded by reset.
REQ-035 in_ready SHALL be 1 during and after reset.
REQ-036 The first accept SHALL occur on the first rising edge with rst_n = 1.

Verification
REQ-037 I-type: imm_select 000, imm_value 0xFFFFF800, base_instr 0x00000013 -> next cycle out_instr 0x80000013, out_err 00.
REQ-038 B-type: imm_select 011, imm_value 0x00000FFE, base_instr 0x00000063 -> out_instr 0x7E000FE3, out_err 00; with imm_value 0x00000FFF -> out_err 10, err_count +1.
REQ-039 Range and select errors: J-type imm_value 0x00100000 -> out_err 01; imm_select 111 with base_instr 0x12345678 -> out_instr 0x12345678, out_err 11.
REQ-040 Backpressure: hold out_ready 0 for 3 cycles with in_valid 1 -> in_ready 0 and outputs stable; then raise out_ready for a continuous stream of 4 requests -> 4 results on 4 consecutive cycles.
REQ-041 Counter: with ERR_CNT_W = 2, send 5 erroring requests -> err_count saturates at 3; assert err_clr together with another error -> err_count 0.
REQ-042 Round trip: for random legal (type, imm_value) pairs, decoding out_instr with the core immediate decode SHALL reproduce imm_value; assert rst_n low mid-stream -> outputs 0 immediately.
